// File: rtl/classifier_cfg_ctrl_pkg.sv
// Shared definitions for the classifier configuration controller: event codes,
// host address map, CTRL bits, reset defaults, FSM states and the config check.
package classifier_cfg_ctrl_pkg;

  localparam logic [1:0] EVENT_C = 2'b00;
  localparam logic [1:0] EVENT_B = 2'b01;
  localparam logic [1:0] EVENT_A = 2'b10;

  localparam logic [2:0] ADDR_A_THR  = 3'd0;
  localparam logic [2:0] ADDR_B_THR  = 3'd1;
  localparam logic [2:0] ADDR_TMO_LO = 3'd2;
  localparam logic [2:0] ADDR_TMO_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_REVERT = 1;

  localparam logic [7:0]  RST_A_THRESH = 8'd5;
  localparam logic [7:0]  RST_B_THRESH = 8'd1;
  localparam logic [15:0] RST_TIMEOUT  = 16'd10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAGED,
    ST_CHECK,
    ST_WAIT_QUIET,
    ST_APPLY
  } cfg_state_e;

  typedef struct packed {
    logic [7:0]  a_thr;
    logic [7:0]  b_thr;
    logic [15:0] tmo;
  } cfg_regs_t;

  // B must be a nonzero threshold strictly below A, and the timeout nonzero.
  function automatic logic cfg_is_valid(input cfg_regs_t r);
    return (r.b_thr != 8'd0) && (r.b_thr < r.a_thr) && (r.tmo != 16'd0);
  endfunction

endpackage

// File: rtl/classifier_cfg_ctrl_quiet_timer.sv
// Quiet/wait counters for the commit window: counts consecutive EVENT_C cycles
// and total cycles spent waiting, both saturating.
module cfg_quiet_timer
  import classifier_cfg_ctrl_pkg::*;
#(
  parameter int QUIET_CYCLES = 4,
  parameter int COMMIT_MAX   = 40000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic [1:0] event_i,
  output logic       quiet_done_o,
  output logic       timeout_done_o
);

  localparam int CNT_W = $clog2(COMMIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(COMMIT_MAX - 1);

  logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             is_quiet;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign is_quiet = (event_i == EVENT_C);

  // Done fires in the cycle that completes the run, so the FSM leaves on that edge.
  assign quiet_done_o   = run_i && is_quiet && (quiet_cnt_q >= QUIET_LAST);
  assign timeout_done_o = run_i && (wait_cnt_q >= WAIT_LAST);

  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (clear_i) begin
      quiet_cnt_d = '0;
      wait_cnt_d  = '0;
    end else if (run_i) begin
      quiet_cnt_d = is_quiet ? sat_inc(quiet_cnt_q) : '0;
      wait_cnt_d  = sat_inc(wait_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      quiet_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      quiet_cnt_q <= quiet_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/classifier_cfg_ctrl.sv
// Host-facing config controller: stages byte writes in shadow registers and
// commits them atomically to the classifier only during a quiet EVENT_C window.
module classifier_cfg_ctrl
  import classifier_cfg_ctrl_pkg::*;
#(
  parameter logic [7:0]  DEF_A_THRESH = RST_A_THRESH,
  parameter logic [7:0]  DEF_B_THRESH = RST_B_THRESH,
  parameter logic [15:0] DEF_TIMEOUT  = RST_TIMEOUT,
  parameter int          QUIET_CYCLES = 4,
  parameter int          COMMIT_MAX   = 40000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        commit_req,
  input  logic [1:0]  event_in,
  output logic [7:0]  class_a_thresh_out,
  output logic [7:0]  class_b_thresh_out,
  output logic [15:0] timeout_period_out,
  output logic        cfg_pending,
  output logic        commit_ack,
  output logic        commit_forced,
  output logic        cfg_error
);

  localparam cfg_regs_t DEF_REGS = {DEF_A_THRESH, DEF_B_THRESH, DEF_TIMEOUT};

  cfg_state_e state_q, state_d;
  cfg_regs_t  shadow_q, shadow_d;
  cfg_regs_t  active_q, active_d;
  logic       pending_q, pending_d;
  logic       ack_q, ack_d;
  logic       forced_q, forced_d;
  logic       err_q, err_d;

  logic accept, wr_ctrl, revert, commit;
  logic quiet_done, timeout_done;

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_STAGED);
  assign accept    = cfg_valid && cfg_ready;
  assign wr_ctrl   = accept && (cfg_addr == ADDR_CTRL);
  assign revert    = wr_ctrl && cfg_data[CTRL_REVERT];
  assign commit    = (cfg_ready && commit_req) || (wr_ctrl && cfg_data[CTRL_COMMIT]);

  cfg_quiet_timer #(
    .QUIET_CYCLES (QUIET_CYCLES),
    .COMMIT_MAX   (COMMIT_MAX)
  ) u_quiet_timer (
    .clk_i          (clk),
    .reset_i        (reset),
    .clear_i        (state_q == ST_CHECK),
    .run_i          (state_q == ST_WAIT_QUIET),
    .event_i        (event_in),
    .quiet_done_o   (quiet_done),
    .timeout_done_o (timeout_done)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ack_d    = 1'b0;
    forced_d = forced_q;
    err_d    = err_q;

    if (accept) begin
      case (cfg_addr)
        ADDR_A_THR: begin
          shadow_d.a_thr = cfg_data;
          state_d        = ST_STAGED;
          err_d          = 1'b0;
        end
        ADDR_B_THR: begin
          shadow_d.b_thr = cfg_data;
          state_d        = ST_STAGED;
          err_d          = 1'b0;
        end
        ADDR_TMO_LO: begin
          shadow_d.tmo[7:0] = cfg_data;
          state_d           = ST_STAGED;
          err_d             = 1'b0;
        end
        ADDR_TMO_HI: begin
          shadow_d.tmo[15:8] = cfg_data;
          state_d            = ST_STAGED;
          err_d              = 1'b0;
        end
        ADDR_CTRL: ;
        default: err_d = 1'b1;
      endcase
    end

    // Revert beats a simultaneous commit from either source.
    if (revert) begin
      shadow_d = active_q;
      state_d  = ST_IDLE;
    end else if (commit) begin
      state_d = ST_CHECK;
    end

    case (state_q)
      ST_CHECK: begin
        if (cfg_is_valid(shadow_q)) begin
          state_d = ST_WAIT_QUIET;
        end else begin
          state_d = ST_STAGED;
          err_d   = 1'b1;
        end
      end
      ST_WAIT_QUIET: begin
        if (quiet_done) begin
          state_d  = ST_APPLY;
          forced_d = 1'b0;
        end else if (timeout_done) begin
          state_d  = ST_APPLY;
          forced_d = 1'b1;
        end
      end
      ST_APPLY: begin
        active_d = shadow_q;
        state_d  = ST_IDLE;
        ack_d    = 1'b1;
      end
      default: ;
    endcase

    pending_d = (shadow_d != active_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shadow_q  <= DEF_REGS;
      active_q  <= DEF_REGS;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      forced_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      forced_q  <= forced_d;
      err_q     <= err_d;
    end
  end

  assign class_a_thresh_out = active_q.a_thr;
  assign class_b_thresh_out = active_q.b_thr;
  assign timeout_period_out = active_q.tmo;
  assign cfg_pending        = pending_q;
  assign commit_ack         = ack_q;
  assign commit_forced      = forced_q;
  assign cfg_error          = err_q;

endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// Scenario bench for classifier_cfg_ctrl: expected applies are queued at commit
// time and popped when commit_ack appears.
module tb_classifier_cfg_ctrl;
  import classifier_cfg_ctrl_pkg::*;

  localparam int QUIET_CYCLES = 4;
  localparam int COMMIT_MAX   = 40000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_addr = 3'd0;
  logic [7:0]  cfg_data = 8'd0;
  logic        commit_req = 1'b0;
  logic [1:0]  event_in = 2'b00;
  logic [7:0]  class_a_thresh_out, class_b_thresh_out;
  logic [15:0] timeout_period_out;
  logic        cfg_pending, commit_ack, commit_forced, cfg_error;

  classifier_cfg_ctrl #(
    .QUIET_CYCLES (QUIET_CYCLES),
    .COMMIT_MAX   (COMMIT_MAX)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_addr           (cfg_addr),
    .cfg_data           (cfg_data),
    .commit_req         (commit_req),
    .event_in           (event_in),
    .class_a_thresh_out (class_a_thresh_out),
    .class_b_thresh_out (class_b_thresh_out),
    .timeout_period_out (timeout_period_out),
    .cfg_pending        (cfg_pending),
    .commit_ack         (commit_ack),
    .commit_forced      (commit_forced),
    .cfg_error          (cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] t;
    logic        forced;
    int          min_cyc;
    int          max_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // m_* mirror the active registers, sh_* the shadow registers.
  logic [7:0]  m_a = 8'd5, m_b = 8'd1, sh_a = 8'd5, sh_b = 8'd1;
  logic [15:0] m_t = 16'd10000, sh_t = 16'd10000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
    case (a)
      3'd0: sh_a = d;
      3'd1: sh_b = d;
      3'd2: sh_t[7:0] = d;
      3'd3: sh_t[15:8] = d;
      default: ;
    endcase
  endtask

  task automatic issue_commit(output int e0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    e0 = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (commit_ack !== 1'b0) begin
        errors++;
        $display("FAIL spurious_ack cycle %0d got ack=%b want 0", cyc, commit_ack);
      end
      step();
    end
  endtask

  task automatic wait_ack(input int bound);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (commit_ack !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (commit_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout got no ack in %0d cycles want ack", bound);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_ack cycle %0d got ack want none", cyc);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {e.a, e.b, e.t}) begin
        errors++;
        $display("FAIL applied_values got %0d/%0d/%0d want %0d/%0d/%0d", class_a_thresh_out,
                 class_b_thresh_out, timeout_period_out, e.a, e.b, e.t);
      end
      checks++;
      if (commit_forced !== e.forced) begin
        errors++;
        $display("FAIL commit_forced got %b want %b", commit_forced, e.forced);
      end
      checks++;
      if (cyc < e.min_cyc || cyc > e.max_cyc) begin
        errors++;
        $display("FAIL ack_latency got cycle %0d want %0d..%0d", cyc, e.min_cyc, e.max_cyc);
      end
      checks++;
      if ({cfg_ready, cfg_pending} !== 2'b10) begin
        errors++;
        $display("FAIL post_apply ready/pending got %b%b want 10", cfg_ready, cfg_pending);
      end
      m_a = e.a;
      m_b = e.b;
      m_t = e.t;
      @(negedge clk);
      checks++;
      if (commit_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_width got ack=%b second cycle want 0", commit_ack);
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {8'd5, 8'd1, 16'd10000}) begin
      errors++;
      $display("FAIL reset_actives got %0d/%0d/%0d want 5/1/10000", class_a_thresh_out,
               class_b_thresh_out, timeout_period_out);
    end
    checks++;
    if ({cfg_ready, cfg_pending, commit_ack, commit_forced, cfg_error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b%b want 10000", cfg_ready, cfg_pending,
               commit_ack, commit_forced, cfg_error);
    end
    step();
  endtask

  task automatic test_commit_quiet();
    int e0;
    event_in = EVENT_C;
    wr(3'd0, 8'd8);
    @(negedge clk);
    checks++;
    if (cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_after_write got %b want 1", cfg_pending);
    end
    step();
    wr(3'd1, 8'd2);
    wr(3'd2, 8'hA0);
    wr(3'd3, 8'h0F);
    issue_commit(e0);
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, e0 + 2 + QUIET_CYCLES, e0 + 2 + QUIET_CYCLES});
    for (int i = 0; i < 2 + QUIET_CYCLES; i++) begin
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b0 || class_a_thresh_out !== m_a || timeout_period_out !== m_t ||
          commit_ack !== 1'b0) begin
        errors++;
        $display("FAIL busy_window step %0d got ready=%b a=%0d t=%0d ack=%b want 0/%0d/%0d/0", i,
                 cfg_ready, class_a_thresh_out, timeout_period_out, commit_ack, m_a, m_t);
      end
    end
    wait_ack(10);
    checks++;
    if (timeout_period_out !== 16'd4000) begin
      errors++;
      $display("FAIL timeout_4000 got %0d want 4000", timeout_period_out);
    end
  endtask

  task automatic test_reset_mid_commit();
    int e0;
    event_in = EVENT_A;
    wr(3'd0, 8'd99);
    issue_commit(e0);
    idle(8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_a = 8'd5;  m_b = 8'd1;  m_t = 16'd10000;
    sh_a = 8'd5; sh_b = 8'd1; sh_t = 16'd10000;
    @(negedge clk);
    checks++;
    if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {m_a, m_b, m_t}) begin
      errors++;
      $display("FAIL midreset_actives got %0d/%0d/%0d want 5/1/10000", class_a_thresh_out,
               class_b_thresh_out, timeout_period_out);
    end
    checks++;
    if ({cfg_ready, cfg_pending, commit_ack, commit_forced, cfg_error} !== 5'b10000) begin
      errors++;
      $display("FAIL midreset_flags got %b%b%b%b%b want 10000", cfg_ready, cfg_pending,
               commit_ack, commit_forced, cfg_error);
    end
    step();
    event_in = EVENT_C;
    idle(12);
  endtask

  task automatic test_quiet_wait();
    int e0, k;
    event_in = EVENT_A;
    wr(3'd0, 8'd20);
    wr(3'd1, 8'd3);
    wr(3'd2, 8'h34);
    wr(3'd3, 8'h12);
    issue_commit(e0);
    for (int i = 1; i < 100; i++) begin
      event_in = (i >= 40 && i <= 42) ? EVENT_C : EVENT_A;
      @(negedge clk);
      checks++;
      if (commit_ack !== 1'b0 || class_a_thresh_out !== m_a || cfg_pending !== 1'b1) begin
        errors++;
        $display("FAIL early_apply step %0d got ack=%b a=%0d pend=%b want 0/%0d/1", i,
                 commit_ack, class_a_thresh_out, cfg_pending, m_a);
      end
      step();
    end
    event_in = EVENT_C;
    k = cyc;
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, k + QUIET_CYCLES + 1, k + QUIET_CYCLES + 1});
    wait_ack(20);
  endtask

  task automatic test_forced();
    int e0;
    event_in = EVENT_B;
    wr(3'd0, 8'd50);
    wr(3'd1, 8'd10);
    issue_commit(e0);
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b1, e0 + COMMIT_MAX + 2, e0 + COMMIT_MAX + 2});
    wait_ack(COMMIT_MAX + 50);
    @(negedge clk);
    checks++;
    if (commit_forced !== 1'b1) begin
      errors++;
      $display("FAIL forced_sticky got %b want 1", commit_forced);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int e0;
    event_in = EVENT_C;
    wr(3'd0, 8'd30);
    wr(3'd1, 8'd4);
    cfg_valid  = 1'b1;
    cfg_addr   = 3'd4;
    cfg_data   = 8'h01;
    commit_req = 1'b1;
    step();
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    e0 = cyc;
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, e0 + 2 + QUIET_CYCLES, e0 + 2 + QUIET_CYCLES});
    wait_ack(20);
    wr(3'd1, 8'd5);
    issue_commit(e0);
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, e0 + 2 + QUIET_CYCLES, e0 + 2 + QUIET_CYCLES});
    wait_ack(20);
    idle(10);
  endtask

  task automatic test_error();
    int e0;
    event_in = EVENT_C;
    wr(3'd1, 8'd9);
    wr(3'd0, 8'd8);
    issue_commit(e0);
    step();
    @(negedge clk);
    checks++;
    if ({cfg_error, cfg_ready, cfg_pending} !== 3'b111 || class_a_thresh_out !== m_a ||
        class_b_thresh_out !== m_b) begin
      errors++;
      $display("FAIL reject_commit got err/rdy/pend=%b%b%b a=%0d b=%0d want 111 %0d %0d",
               cfg_error, cfg_ready, cfg_pending, class_a_thresh_out, class_b_thresh_out, m_a, m_b);
    end
    step();
    idle(10);
    wr(3'd0, 8'd10);
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got %b want 0", cfg_error);
    end
    step();
    wr(3'd6, 8'h55);
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b1 || cfg_pending !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr got err=%b pend=%b rdy=%b want 1/1/1", cfg_error, cfg_pending,
               cfg_ready);
    end
    step();
    issue_commit(e0);
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, e0 + 2 + QUIET_CYCLES, e0 + 2 + QUIET_CYCLES});
    wait_ack(20);
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky got %b want 1", cfg_error);
    end
    step();
  endtask

  task automatic test_revert();
    int e0;
    event_in = EVENT_C;
    wr(3'd0, 8'd77);
    @(negedge clk);
    checks++;
    if (cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL revert_staged got pend=%b want 1", cfg_pending);
    end
    step();
    cfg_valid  = 1'b1;
    cfg_addr   = 3'd4;
    cfg_data   = 8'h03;
    commit_req = 1'b1;
    step();
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    sh_a = m_a;
    sh_b = m_b;
    sh_t = m_t;
    @(negedge clk);
    checks++;
    if (cfg_pending !== 1'b0 || cfg_ready !== 1'b1 || class_a_thresh_out !== m_a) begin
      errors++;
      $display("FAIL revert got pend=%b rdy=%b a=%0d want 0/1/%0d", cfg_pending, cfg_ready,
               class_a_thresh_out, m_a);
    end
    step();
    idle(12);
    issue_commit(e0);
    exp_q.push_back('{sh_a, sh_b, sh_t, 1'b0, e0 + 2 + QUIET_CYCLES, e0 + 2 + QUIET_CYCLES});
    wait_ack(20);
  endtask

  initial begin
    test_reset();
    test_commit_quiet();
    test_reset_mid_commit();
    test_quiet_wait();
    test_forced();
    test_back_to_back();
    test_error();
    test_revert();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d queued want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
